instruction_cache: RTL and testbench
====================================

// Module: instruction_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache sitting directly upstream of the instruction fetcher.
//  Hits answer combinationally in the same cycle as the fetcher's request.
//  Misses run a multi-word line fill from the memory controller, one outstanding word request at a time.
//  No writes and no coherence: instruction memory is treated as immutable.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width
//  INDEX_BITS  6   log2(number of lines); 64 lines
//  WORD_BITS   2   log2(words per line); 4 x 32-bit words = 16 B per line
// PORTS
//  Sys_clk     in   1           clock; all state updates on the rising edge
//  Sys_rst     in   1           asynchronous, active-high reset
//  Sys_rdy     in   1           global enable; when low, all state is frozen
//  IFIC_en     in   1           fetch request (level), valid in the same cycle as IFIC_addr
//  IFIC_addr   in   ADDR_WIDTH  fetch byte address; bits [1:0] are always 0
//  ICIF_en     out  1           hit / data valid this cycle
//  ICIF_data   out  32          instruction word
//  ICMC_en     out  1           memory word request (level)
//  ICMC_addr   out  ADDR_WIDTH  byte address of the requested word
//  MCIC_en     in   1           one-cycle pulse: MCIC_data is valid
//  MCIC_data   in   32          returned word
// BEHAVIOUR
//  Address split:
//   - word  = addr[WORD_BITS+1:2]
//   - index = addr[INDEX_BITS+WORD_BITS+1:WORD_BITS+2]
//   - tag   = the remaining upper bits
//  Storage: valid[2^INDEX_BITS], tag[2^INDEX_BITS], data[2^(INDEX_BITS+WORD_BITS)] x 32.
//   - Only the valid bits are reset; tag and data arrays are not.
//  Reset (async): state=IDLE, all valid bits=0, word_cnt=0, ICMC_en=0, ICMC_addr=0.
//   - ICIF_en=0 while Sys_rst is high.
//   - ICIF_data is don't-care whenever ICIF_en=0.
//  Hit path (combinational):
//   - ICIF_en = IFIC_en && state==IDLE && valid[index] && tag matches.
//   - ICIF_data = data[index,word].
//   - Zero-cycle latency.
//  FSM state IDLE:
//   - Condition: Sys_rdy && IFIC_en && miss.
//   - Actions: latch fill_tag/fill_index from IFIC_addr; word_cnt<=0; ICMC_en<=1;
//     ICMC_addr<={tag,index,WORD_BITS'b0,2'b00}; go to FILL.
//  FSM state FILL:
//   - ICIF_en stays 0 regardless of address.
//   - On MCIC_en: data[fill_index,word_cnt]<=MCIC_data; word_cnt<=word_cnt+1; ICMC_addr+=4.
//   - On MCIC_en with word_cnt==2^WORD_BITS-1:
//     - valid[fill_index]<=1 and tag[fill_index]<=fill_tag, written on the same edge as the last word;
//     - ICMC_en<=0; state<=IDLE; word_cnt wraps to 0.
//     - The earliest hit on the filled line is the following cycle.
//   - valid[fill_index] is cleared on entry to FILL, so a half-filled line can never hit.
//  Miss latency: 1 (request) + 2^WORD_BITS x memory latency; the hit is seen the cycle after the last MCIC_en.
//  Handshake rules:
//   - ICMC_en stays high for the whole fill.
//   - ICMC_addr changes only on the edge after an MCIC_en.
//   - The memory controller must not pulse MCIC_en while ICMC_en=0; any such pulse is ignored.
//  Simultaneous events:
//   - The fetcher drops IFIC_en or changes IFIC_addr (redirect) during FILL: the fill always completes
//     for the latched line, with no abort, and the new address is looked up in IDLE afterwards.
//   - A miss to another index in the same cycle the fill completes is impossible: state is still FILL.
//  Conflict: a new fill to an occupied index overwrites that line (direct-mapped eviction).
//  Sys_rdy=0: no state, counter or array update; MCIC_en is ignored.
//   - Outputs hold their registered values; ICIF_en follows the combinational hit rule.
//  Reset mid-FILL: immediately IDLE, ICMC_en=0, and the partially filled line stays invalid.
// TESTING
//  1. Reset, then IFIC_en=1, addr=0x10 -> ICIF_en=0; next cycle ICMC_en=1, ICMC_addr=0x10,
//     then 0x14, 0x18, 0x1C after each MCIC_en.
//  2. After fill 1 completes, addr=0x18 -> ICIF_en=1 in the same cycle; ICIF_data = third word returned.
//  3. Conflict: addr=0x410 (index 1, new tag) -> miss and fill from 0x410;
//     afterwards 0x10 misses and 0x414 hits.
//  4. Redirect to 0x200 while filling 0x10 -> fill of 0x10-0x1C completes, then 0x200 misses;
//     0x10 hits afterwards.
//  5. Assert Sys_rst after the 2nd MCIC_en of a fill -> ICMC_en=0 immediately;
//     re-request of 0x10 misses and refills from 0x10.
//  6. Sys_rdy=0 for 3 cycles mid-fill with MCIC_en pulsed -> word_cnt and ICMC_addr unchanged;
//     the fill resumes correctly when Sys_rdy=1.

Source files
------------

// File: rtl/instruction_cache_if.sv
// Fetcher-side and memory-controller-side signals of the instruction cache.
// The cache is the slave; the master modport is the combined fetcher/memory view.
interface instruction_cache_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  IFIC_en;
  logic [ADDR_WIDTH-1:0] IFIC_addr;
  logic                  ICIF_en;
  logic [31:0]           ICIF_data;
  logic                  ICMC_en;
  logic [ADDR_WIDTH-1:0] ICMC_addr;
  logic                  MCIC_en;
  logic [31:0]           MCIC_data;

  modport slave (
    input  IFIC_en, IFIC_addr, MCIC_en, MCIC_data,
    output ICIF_en, ICIF_data, ICMC_en, ICMC_addr
  );

  modport master (
    output IFIC_en, IFIC_addr, MCIC_en, MCIC_data,
    input  ICIF_en, ICIF_data, ICMC_en, ICMC_addr
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, and
// line fill from the memory controller one word request at a time.
module instruction_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int WORD_BITS  = 2
) (
  input  logic                Sys_clk,
  input  logic                Sys_rst,
  input  logic                Sys_rdy,
  instruction_cache_if.slave  bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << WORD_BITS;
  localparam int OFF_BITS = WORD_BITS + 2;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFF_BITS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e                  state_q;
  logic [WORD_BITS-1:0]    word_cnt_q;
  logic [WORD_BITS-1:0]    word_cnt_d;
  logic                    icmc_en_q;
  logic [ADDR_WIDTH-1:0]   icmc_addr_q;
  logic [ADDR_WIDTH-1:0]   icmc_addr_d;
  logic [TAG_BITS-1:0]     fill_tag_q;
  logic [INDEX_BITS-1:0]   fill_index_q;
  logic [LINES-1:0]        valid_q;
  logic [TAG_BITS-1:0]     tag_q  [LINES];
  logic [31:0]             data_q [LINES*WORDS];

  logic [WORD_BITS-1:0]    req_word_s;
  logic [INDEX_BITS-1:0]   req_index_s;
  logic [TAG_BITS-1:0]     req_tag_s;
  logic                    lookup_hit_s;
  logic                    start_fill_s;
  logic                    word_ret_s;
  logic                    last_word_s;
  logic                    unused_addr_s;

  assign req_word_s    = bus.IFIC_addr[OFF_BITS-1:2];
  assign req_index_s   = bus.IFIC_addr[INDEX_BITS+OFF_BITS-1:OFF_BITS];
  assign req_tag_s     = bus.IFIC_addr[ADDR_WIDTH-1:INDEX_BITS+OFF_BITS];
  assign unused_addr_s = ^bus.IFIC_addr[1:0];

  // Lookup, fill-start and word-return decode; Sys_rdy low suppresses every state change.
  always_comb begin
    lookup_hit_s = valid_q[req_index_s] && (tag_q[req_index_s] == req_tag_s);
    start_fill_s = 1'b0;
    word_ret_s   = 1'b0;
    last_word_s  = 1'b0;
    word_cnt_d   = word_cnt_q + WORD_BITS'(1);
    icmc_addr_d  = icmc_addr_q + ADDR_WIDTH'(4);
    case (state_q)
      IDLE: begin
        start_fill_s = Sys_rdy && bus.IFIC_en && !lookup_hit_s;
      end
      FILL: begin
        word_ret_s  = Sys_rdy && bus.MCIC_en;
        last_word_s = word_ret_s && (word_cnt_q == WORD_BITS'(WORDS - 1));
      end
      default: begin
        start_fill_s = 1'b0;
      end
    endcase
  end

  assign bus.ICIF_en   = !Sys_rst && bus.IFIC_en && (state_q == IDLE) && lookup_hit_s;
  assign bus.ICIF_data = data_q[{req_index_s, req_word_s}];
  assign bus.ICMC_en   = icmc_en_q;
  assign bus.ICMC_addr = icmc_addr_q;

  // Fill FSM; the target line is invalidated on entry so a partial line never hits.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      icmc_en_q    <= 1'b0;
      icmc_addr_q  <= '0;
      fill_tag_q   <= '0;
      fill_index_q <= '0;
      valid_q      <= '0;
    end else if (start_fill_s) begin
      state_q              <= FILL;
      fill_tag_q           <= req_tag_s;
      fill_index_q         <= req_index_s;
      word_cnt_q           <= '0;
      icmc_en_q            <= 1'b1;
      icmc_addr_q          <= {req_tag_s, req_index_s, {OFF_BITS{1'b0}}};
      valid_q[req_index_s] <= 1'b0;
    end else if (word_ret_s) begin
      word_cnt_q  <= word_cnt_d;
      icmc_addr_q <= icmc_addr_d;
      if (last_word_s) begin
        valid_q[fill_index_q] <= 1'b1;
        icmc_en_q             <= 1'b0;
        state_q               <= IDLE;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge Sys_clk) begin
    if (word_ret_s) begin
      data_q[{fill_index_q, word_cnt_q}] <= bus.MCIC_data;
    end
    if (last_word_s) begin
      tag_q[fill_index_q] <= fill_tag_q;
    end
  end
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench: the bench plays fetcher and memory controller and
// compares against a line-level model of which memory lines are cached.
module tb_instruction_cache;
  logic Sys_clk = 1'b0;
  logic Sys_rst;
  logic Sys_rdy;

  instruction_cache_if #(.ADDR_WIDTH(32)) bus ();

  instruction_cache dut (
    .Sys_clk (Sys_clk),
    .Sys_rst (Sys_rst),
    .Sys_rdy (Sys_rdy),
    .bus     (bus)
  );

  always #5 Sys_clk = ~Sys_clk;

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    int          lat;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        m_valid [64];
  logic [27:0] m_line  [64];
  vec_t        tbl     [15];

  // Immutable instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[9:4]] && (m_line[a[9:4]] == a[31:4]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge Sys_clk);
    Sys_rst = 1'b1; Sys_rdy = 1'b1; bus.MCIC_en = 1'b0;
    bus.IFIC_en = 1'b1; bus.IFIC_addr = 32'h10;
    #1;
    chk("rst_icif_en", bus.ICIF_en, 0);
    chk("rst_icmc_en", bus.ICMC_en, 0);
    chk("rst_icmc_addr", bus.ICMC_addr, 0);
    bus.IFIC_en = 1'b0;
    @(negedge Sys_clk);
    Sys_rst = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // Called just after a miss was presented; acts as memory with `lat` cycles per word.
  task automatic serve_fill(input logic [31:0] a, input int lat, input logic [31:0] redirect, input bit stall);
    logic [31:0] base;
    logic [31:0] cur;
    base = {a[31:4], 4'h0};
    cur  = a;
    m_valid[a[9:4]] = 1'b0;
    for (int w = 0; w < 4; w++) begin
      if (stall && w == 1) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge Sys_clk);
          Sys_rdy = 1'b0; bus.MCIC_en = 1'b1; bus.MCIC_data = 32'hDEAD_BEEF;
          #1;
          chk("stall_icmc_en", bus.ICMC_en, 1);
          chk("stall_icmc_addr", bus.ICMC_addr, base + 32'h4);
        end
      end
      for (int l = 0; l < lat; l++) begin
        @(negedge Sys_clk);
        bus.MCIC_en = 1'b0; Sys_rdy = 1'b1;
        if (redirect != 32'h0 && w == 1) begin
          cur = redirect;
          bus.IFIC_addr = redirect;
        end
        #1;
        chk("icmc_en", bus.ICMC_en, 1);
        chk("icmc_addr", bus.ICMC_addr, base + 32'(4 * w));
        chk("fill_icif_en", bus.ICIF_en, 0);
      end
      bus.MCIC_en = 1'b1;
      bus.MCIC_data = mem_word(base + 32'(4 * w));
    end
    @(negedge Sys_clk);
    bus.MCIC_en = 1'b0;
    #1;
    m_valid[a[9:4]] = 1'b1;
    m_line[a[9:4]]  = a[31:4];
    chk("fill_done_icmc_en", bus.ICMC_en, 0);
    chk("post_fill_hit", bus.ICIF_en, model_hit(cur));
    if (model_hit(cur)) chk("post_fill_data", bus.ICIF_data, mem_word(cur));
  endtask

  task automatic lookup(input logic [31:0] a, input bit exp_hit, input int lat, input bit stall);
    @(negedge Sys_clk);
    bus.MCIC_en = 1'b0; Sys_rdy = 1'b1;
    bus.IFIC_en = 1'b1; bus.IFIC_addr = a;
    #1;
    chk("lookup_hit", bus.ICIF_en, exp_hit);
    if (exp_hit) chk("hit_data", bus.ICIF_data, mem_word(a));
    else serve_fill(a, lat, 32'h0, stall);
  endtask

  task automatic idle_pulse();
    @(negedge Sys_clk);
    bus.IFIC_en = 1'b0; bus.MCIC_en = 1'b1; bus.MCIC_data = 32'($urandom);
    @(negedge Sys_clk);
    bus.MCIC_en = 1'b0;
    #1;
    chk("idle_icmc_en", bus.ICMC_en, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Sys_rst = 1'b1; Sys_rdy = 1'b1;
    bus.IFIC_en = 1'b0; bus.IFIC_addr = 32'h0;
    bus.MCIC_en = 1'b0; bus.MCIC_data = 32'h0;

    tbl[0]  = '{32'h0000_0010, 1'b0, 1};
    tbl[1]  = '{32'h0000_0018, 1'b1, 1};
    tbl[2]  = '{32'h0000_001C, 1'b1, 1};
    tbl[3]  = '{32'h0000_0410, 1'b0, 2};
    tbl[4]  = '{32'h0000_0414, 1'b1, 1};
    tbl[5]  = '{32'h0000_0010, 1'b0, 1};
    tbl[6]  = '{32'h0000_0414, 1'b0, 3};
    tbl[7]  = '{32'h0000_0014, 1'b0, 1};
    tbl[8]  = '{32'h0000_0000, 1'b0, 1};
    tbl[9]  = '{32'h0000_03FC, 1'b0, 2};
    tbl[10] = '{32'h0000_03F0, 1'b1, 1};
    tbl[11] = '{32'hFFFF_FFFC, 1'b0, 1};
    tbl[12] = '{32'h0000_03F4, 1'b0, 1};
    tbl[13] = '{32'hFFFF_FFF0, 1'b0, 1};
    tbl[14] = '{32'h0000_0004, 1'b1, 1};

    do_reset();
    for (int i = 0; i < 15; i++) lookup(tbl[i].addr, tbl[i].hit, tbl[i].lat, 1'b0);

    // Redirect during a fill: the latched line still completes.
    do_reset();
    @(negedge Sys_clk);
    bus.IFIC_en = 1'b1; bus.IFIC_addr = 32'h10;
    #1;
    chk("redir_first_miss", bus.ICIF_en, 0);
    serve_fill(32'h10, 2, 32'h200, 1'b0);
    serve_fill(32'h200, 1, 32'h0, 1'b0);
    lookup(32'h10, 1'b1, 1, 1'b0);

    // Reset after the second returned word.
    do_reset();
    @(negedge Sys_clk);
    bus.IFIC_en = 1'b1; bus.IFIC_addr = 32'h10;
    #1;
    chk("t5_miss", bus.ICIF_en, 0);
    for (int w = 0; w < 2; w++) begin
      @(negedge Sys_clk);
      bus.MCIC_en = 1'b0;
      #1;
      chk("t5_icmc_addr", bus.ICMC_addr, 32'h10 + 32'(4 * w));
      bus.MCIC_en = 1'b1; bus.MCIC_data = mem_word(32'h10 + 32'(4 * w));
    end
    @(negedge Sys_clk);
    bus.MCIC_en = 1'b0;
    #1;
    chk("t5_addr_before_rst", bus.ICMC_addr, 32'h18);
    Sys_rst = 1'b1;
    #1;
    chk("t5_rst_icmc_en", bus.ICMC_en, 0);
    chk("t5_rst_icif_en", bus.ICIF_en, 0);
    bus.IFIC_en = 1'b0;
    @(negedge Sys_clk);
    Sys_rst = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    lookup(32'h10, 1'b0, 1, 1'b0);
    lookup(32'h14, 1'b1, 1, 1'b0);

    // Sys_rdy low mid-fill with stray MCIC_en pulses.
    do_reset();
    lookup(32'h10, 1'b0, 2, 1'b1);
    lookup(32'h14, 1'b1, 1, 1'b0);
    lookup(32'h1C, 1'b1, 1, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      int unsigned tsel;
      int unsigned idx;
      int unsigned wd;
      tsel = $urandom_range(0, 3);
      idx  = $urandom_range(0, 7) * 9;
      wd   = $urandom_range(0, 3);
      a = (32'(tsel) * 32'h0040_0400) | (32'(idx) << 4) | (32'(wd) << 2);
      if ($urandom_range(0, 9) == 0) idle_pulse();
      lookup(a, model_hit(a), int'($urandom_range(1, 3)), $urandom_range(0, 15) == 0);
    end

    bus.IFIC_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
